// File: rtl/imem_load_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
//   Shared definitions for the instruction-memory load arbiter:
//   FSM state encoding, the NOP instruction returned while the core is stalled,
//   default address/data widths and the reset-state helper.
//   Optional feature macro used by this slice: IMEM_LOAD_CHECKSUM_EN.
// ----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 32;

    // addi x0, x0, 0 : harmless filler while the core is held
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } imem_state_e;

    // State entered on reset: hold the core in LOAD until a program arrives,
    // or let it fetch straight away.
    function automatic imem_state_e reset_state(input logic boot_hold);
        imem_state_e st;
        if (boot_hold) begin
            st = ST_LOAD;
        end else begin
            st = ST_RUN;
        end
        return st;
    endfunction

endpackage

// File: rtl/imem_load_arbiter_if.sv
// ----------------------------------------------------------------------------
// imem_load_arbiter_if
//   Program-loader bus (request + valid/ready write channel).
//   master : the loader (UART/debug) -- drives ld_req/ld_valid/ld_addr/ld_data/ld_last
//   slave  : the arbiter             -- drives ld_ready
//   Optional feature macro used by this slice: IMEM_LOAD_CHECKSUM_EN (not used here).
// ----------------------------------------------------------------------------
interface imem_load_arbiter_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
);
    logic              ld_req;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    modport master (
        output ld_req, ld_valid, ld_addr, ld_data, ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_req, ld_valid, ld_addr, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/imem_load_arbiter_counter.sv
// ----------------------------------------------------------------------------
// imem_load_counter
//   Counts accepted loader words, saturating at 2**ADDR_W, and (optionally)
//   keeps a running XOR checksum of the accepted data.
//   Feature macro: IMEM_LOAD_CHECKSUM_EN adds the checksum output.
//   Ports:
//     clk, rst_n   clock, synchronous active-low reset
//     clear        restart counting (entering a new load)
//     accept       one loader word accepted this cycle
//     data         accepted word
//     count        words accepted, ADDR_W+1 bits, saturating
//     checksum     XOR of accepted words (only with IMEM_LOAD_CHECKSUM_EN)
// ----------------------------------------------------------------------------
module imem_load_counter
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W:0]   count
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W:0] CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_d;

    // Next word count: clear wins, otherwise increment until full depth.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = CNT_ZERO;
        end else if (accept && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Word-count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_d;

    // Next checksum: cleared together with the count, folds in each accepted word.
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = {DATA_W{1'b0}};
        end else if (accept) begin
            sum_d = sum_q ^ data;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register; keeps its value after the load completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= {DATA_W{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    // Without the checksum the data input has no consumer.
    logic unused_data_s;
    assign unused_data_s = ^data;
`endif

endmodule

// File: rtl/imem_load_arbiter.sv
// ----------------------------------------------------------------------------
// imem_load_arbiter
//   Owns the single port of the instruction memory and shares it between CPU
//   fetch (read) and a program loader (write). Sequence on a reload:
//   RUN -> DRAIN (1 cycle) -> LOAD (until last word) -> RELEASE (1 cycle) -> RUN.
//   Feature macro: IMEM_LOAD_CHECKSUM_EN adds output ld_checksum.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     cpu_addr/instr  fetch address / instruction (NOP unless RUN)
//     cpu_stall       core must hold its PC
//     ld (slave)      loader bus: ld_req, ld_valid/ld_ready, ld_addr, ld_data, ld_last
//     mem_*           memory port: write enable, address, write data, read data
//     load_done       one-cycle pulse when a load finishes
//     words_loaded    words accepted in the current/last load (saturating)
//     ld_checksum     XOR of accepted words (only with IMEM_LOAD_CHECKSUM_EN)
// ----------------------------------------------------------------------------
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter bit BOOT_HOLD = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic [DATA_W-1:0]   cpu_instr,
    output logic                cpu_stall,
    imem_load_arbiter_if.slave  ld,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                load_done,
    output logic [ADDR_W:0]     words_loaded
`ifdef IMEM_LOAD_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   ld_checksum
`endif
);

    localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP_INSTR);

    imem_state_e state_q;
    imem_state_e state_d;
    logic        ld_ready_s;
    logic        accept_s;

    // Next-state: ld_req only matters in RUN, ld_last only on a LOAD handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ld.ld_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (ld.ld_valid && ld.ld_last) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= reset_state(BOOT_HOLD);
        end else begin
            state_q <= state_d;
        end
    end

    // Port muxing decoded from the registered state; fetch read is zero-latency.
    always_comb begin
        cpu_stall  = 1'b1;
        cpu_instr  = NOP_W;
        ld_ready_s = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = {DATA_W{1'b0}};
        load_done  = 1'b0;
        case (state_q)
            ST_RUN: begin
                cpu_stall = 1'b0;
                cpu_instr = mem_rdata;
            end
            ST_DRAIN: begin
                cpu_stall = 1'b1;
            end
            ST_LOAD: begin
                ld_ready_s = 1'b1;
                mem_addr   = ld.ld_addr;
                mem_wdata  = ld.ld_data;
            end
            ST_RELEASE: begin
                load_done = 1'b1;
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

    // A write happens on the same edge as the loader handshake.
    assign accept_s    = ld.ld_valid & ld_ready_s;
    assign mem_en      = accept_s;
    assign ld.ld_ready = ld_ready_s;

    imem_load_counter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == ST_DRAIN),
        .accept   (accept_s),
        .data     (ld.ld_data),
        .count    (words_loaded)
`ifdef IMEM_LOAD_CHECKSUM_EN
        ,
        .checksum (ld_checksum)
`endif
    );

endmodule

// File: tb/tb_imem_load_arbiter.sv
module tb_imem_load_arbiter;
    import imem_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam bit BOOT = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (BOOT_HOLD=1) ----------------
    imem_load_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ld_bus ();
    logic [AW-1:0] cpu_addr, mem_addr;
    logic [DW-1:0] cpu_instr, mem_wdata, mem_rdata;
    logic          cpu_stall, mem_en, load_done;
    logic [AW:0]   words_loaded;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DW-1:0] ld_checksum;
`endif

    imem_load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BOOT_HOLD(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
        .cpu_stall(cpu_stall), .ld(ld_bus), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .load_done(load_done),
        .words_loaded(words_loaded)
`ifdef IMEM_LOAD_CHECKSUM_EN
        , .ld_checksum(ld_checksum)
`endif
    );

    // Physical memory behind the main DUT
    logic [DW-1:0] imem [0:255];
    logic wipe = 1'b1;
    assign mem_rdata = imem[mem_addr];
    always @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < 256; i++) imem[i] <= 32'h0;
        end else if (mem_en) begin
            imem[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- second DUT (BOOT_HOLD=0), never requested ----------------
    imem_load_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ld_bus0 ();
    logic [AW-1:0] cpu_addr0, mem_addr0;
    logic [DW-1:0] cpu_instr0, mem_wdata0, mem_rdata0;
    logic          cpu_stall0, mem_en0, load_done0;
    logic [AW:0]   words_loaded0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DW-1:0] ld_checksum0;
`endif
    assign mem_rdata0 = 32'h0BAD_F00D;

    imem_load_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BOOT_HOLD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr0), .cpu_instr(cpu_instr0),
        .cpu_stall(cpu_stall0), .ld(ld_bus0), .mem_en(mem_en0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .load_done(load_done0),
        .words_loaded(words_loaded0)
`ifdef IMEM_LOAD_CHECKSUM_EN
        , .ld_checksum(ld_checksum0)
`endif
    );

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        stall;
        logic        ready;
        logic        en;
        logic        done;
        logic [8:0]  words;
        logic [31:0] xsum;
        logic        addr_chk;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t expq[$];

    // ---------------- reference model (behavioural) ----------------
    typedef enum {FETCH, FLUSH, ACCEPT, HANDBACK} mode_t;
    mode_t       m_mode;
    int          m_words;
    logic [31:0] m_xsum;
    logic [31:0] ref_mem [0:255];
    bit          model_known = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    end

    // One clock of stimulus: drive at negedge, record expectation, advance model.
    task automatic tick(input bit rst_v, input bit req, input bit valid, input bit last,
                        input logic [7:0] laddr, input logic [31:0] ldata, input logic [7:0] caddr);
        exp_t e;
        bit   fire;
        @(negedge clk);
        rst_n           = rst_v;
        ld_bus.ld_req   = req;
        ld_bus.ld_valid = valid;
        ld_bus.ld_last  = last;
        ld_bus.ld_addr  = laddr;
        ld_bus.ld_data  = ldata;
        cpu_addr        = caddr;
        ld_bus0.ld_req   = 1'b0;
        ld_bus0.ld_valid = 1'($urandom_range(0, 1));
        ld_bus0.ld_last  = 1'($urandom_range(0, 1));
        ld_bus0.ld_addr  = 8'($urandom);
        ld_bus0.ld_data  = $urandom;
        cpu_addr0        = 8'($urandom);
        #1;
        if (model_known) begin
            fire       = (m_mode == ACCEPT) && valid;
            e.instr    = (m_mode == FETCH) ? ref_mem[caddr] : NOP_INSTR;
            e.stall    = (m_mode != FETCH);
            e.ready    = (m_mode == ACCEPT);
            e.en       = fire;
            e.done     = (m_mode == HANDBACK);
            e.words    = 9'(m_words);
            e.xsum     = m_xsum;
            e.addr_chk = (m_mode == FETCH) || (m_mode == ACCEPT);
            e.addr     = (m_mode == ACCEPT) ? laddr : caddr;
            e.wdata    = ldata;
            expq.push_back(e);
            // BOOT_HOLD=0 instance never sees ld_req: it must stay fetching.
            chk("b0_stall", 32'(cpu_stall0), 32'h0);
            chk("b0_ready", 32'(ld_bus0.ld_ready), 32'h0);
            chk("b0_mem_en", 32'(mem_en0), 32'h0);
            chk("b0_instr", cpu_instr0, 32'h0BAD_F00D);
            // advance the model to the next edge
            if (fire) ref_mem[laddr] = ldata;
            if (!rst_v) begin
                m_mode  = BOOT ? ACCEPT : FETCH;
                m_words = 0;
                m_xsum  = 32'h0;
            end else begin
                case (m_mode)
                    FETCH:    if (req) m_mode = FLUSH;
                    FLUSH:    begin m_words = 0; m_xsum = 32'h0; m_mode = ACCEPT; end
                    ACCEPT:   if (fire) begin
                                  m_words = (m_words < 256) ? m_words + 1 : 256;
                                  m_xsum  = m_xsum ^ ldata;
                                  if (last) m_mode = HANDBACK;
                              end
                    HANDBACK: m_mode = FETCH;
                    default:  m_mode = FETCH;
                endcase
            end
        end else if (!rst_v) begin
            m_mode      = BOOT ? ACCEPT : FETCH;
            m_words     = 0;
            m_xsum      = 32'h0;
            model_known = 1'b1;
        end
    endtask

    // ---------------- monitor: pops and compares shortly before each posedge ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("cpu_instr", cpu_instr, e.instr);
                chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
                chk("ld_ready", 32'(ld_bus.ld_ready), 32'(e.ready));
                chk("mem_en", 32'(mem_en), 32'(e.en));
                chk("load_done", 32'(load_done), 32'(e.done));
                chk("words_loaded", 32'(words_loaded), 32'(e.words));
                if (e.addr_chk) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                if (e.en) chk("mem_wdata", mem_wdata, e.wdata);
`ifdef IMEM_LOAD_CHECKSUM_EN
                chk("ld_checksum", ld_checksum, e.xsum);
`endif
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), $urandom, 8'($urandom));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ld_bus.ld_req = 1'b0; ld_bus.ld_valid = 1'b0; ld_bus.ld_last = 1'b0;
        ld_bus.ld_addr = 8'h00; ld_bus.ld_data = 32'h0; cpu_addr = 8'h00;
        ld_bus0.ld_req = 1'b0; ld_bus0.ld_valid = 1'b0; ld_bus0.ld_last = 1'b0;
        ld_bus0.ld_addr = 8'h00; ld_bus0.ld_data = 32'h0; cpu_addr0 = 8'h00;

        // 1: boot load of two words, then fetch them
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        wipe = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0050_0093, 8'h00);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 32'h00A0_0113, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 32'h0, 8'h01);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 32'h0, 8'h01);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 32'h0, 8'h00);
        idle(3);

        // 2: ld_req together with ld_valid; 3: five words with valid toggling
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'h05, $urandom, 8'h01);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h06, $urandom, 8'h01);
        for (int i = 0; i < 9; i++)
            tick(1'b1, 1'b0, (i % 2) == 0, i == 8, 8'(8'h10 + i), $urandom, 8'h00);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h07, $urandom, 8'h05);
        for (int k = 0; k < 6; k++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'(8'h10 + 2 * k));

        // 4: reset after 3 of 6 words, then finish with one word and read back
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        for (int k = 0; k < 3; k++)
            tick(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + k), $urandom, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 32'h0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 32'h0, 8'h00);
        tick(1'b1, 1'b0, 1'b1, 1'b1, 8'h40, $urandom, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h30);
        for (int k = 0; k < 4; k++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'(8'h30 + k));

        // 5: 257 handshakes, address 0 written twice
        tick(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        for (int i = 0; i < 257; i++)
            tick(1'b1, 1'b0, 1'b1, i == 256, 8'(i), $urandom, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 8'h00);
        idle(4);

        // random traffic
        for (int i = 0; i < 200; i++)
            tick($urandom_range(0, 29) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, 8'($urandom), $urandom, 8'($urandom));
        idle(3);

        @(negedge clk);
        #6;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
